uart_rx_bit_sampler: RTL and testbench

Serial receive front end that turns an asynchronous, LSB-first UART-style line into the bit stream and shift strobes consumed by the right-shift register stage (`D`, `h` inputs), which places the first received bit at bit 0 after `N_BITS` shifts. It synchronises the line, detects and validates the start bit, samples each data bit at mid-bit, checks the stop bit, and flags frame completion or framing error. It sits directly upstream of the shift register in the receive path.

---
 rtl/uart_rx_bit_sampler.sv | 155 +++++++++++++++
 tb/tb_uart_rx_bit_sampler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_bit_sampler.sv
// rtl/uart_rx_bit_sampler.sv - UART receive front end: line sync, start validation, mid-bit sampling, stop check
module uart_rx_bit_sampler #(
  parameter int CLKS_PER_BIT = 434,
  parameter int N_BITS       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic D,
  output logic h,
  output logic done,
  output logic frame_err,
  output logic busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(N_BITS + 1);

  // Start bit is validated half a bit in; data and stop are sampled a full bit apart after that.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_rx_prev;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;
  logic             r_d;
  logic             w_d_next;
  logic             r_h;
  logic             w_h_next;
  logic             r_done;
  logic             w_done_next;
  logic             r_err;
  logic             w_err_next;

  // Two-flop synchroniser plus one history flop for falling-edge detection; idle-high reset values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next-output decode; strobes default low so they last exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CNT_W'(1);
    w_idx_next   = r_idx;
    w_d_next     = r_d;
    w_h_next     = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        // Only a high-to-low transition starts a frame, so a line stuck low stays idle.
        if (r_rx_prev && !r_rx_s) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_next = '0;
          if (!r_rx_s) begin
            w_state_next = S_DATA;
            w_idx_next   = '0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_next = '0;
          w_d_next   = r_rx_s;
          w_h_next   = 1'b1;
          w_idx_next = r_idx + IDX_W'(1);
          if (r_idx == IDX_LAST) begin
            w_state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
          if (r_rx_s) begin
            w_done_next = 1'b1;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Registered datapath: bit timer, bit index, sampled bit and strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_d    <= 1'b0;
      r_h    <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_idx  <= w_idx_next;
      r_d    <= w_d_next;
      r_h    <= w_h_next;
      r_done <= w_done_next;
      r_err  <= w_err_next;
    end
  end

  assign D         = r_d;
  assign h         = r_h;
  assign done      = r_done;
  assign frame_err = r_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// tb/tb_uart_rx_bit_sampler.sv - self-checking bench for uart_rx_bit_sampler with downstream shift register
module tb_uart_rx_bit_sampler;

  localparam int C = 8;
  localparam int N = 8;

  logic clk;
  logic rst;
  logic rx;
  logic D;
  logic h;
  logic done;
  logic frame_err;
  logic busy;

  uart_rx_bit_sampler #(
    .CLKS_PER_BIT(C),
    .N_BITS      (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .D        (D),
    .h        (h),
    .done     (done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream right-shift register: first received bit lands at bit 0 after N shifts.
  logic [N-1:0] sr;
  always @(posedge clk or negedge rst) begin
    if (!rst) sr <= '0;
    else if (h) sr <= {D, sr[N-1:1]};
  end

  int         exp_h_cyc[$];
  int         act_h_cyc[$];
  bit         exp_d[$];
  bit         act_d[$];
  int         exp_done_cyc[$];
  int         act_done_cyc[$];
  logic [7:0] exp_done_val[$];
  logic [7:0] act_done_val[$];
  int         exp_err_cyc[$];
  int         act_err_cyc[$];
  int         viol = 0;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Event monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (rst) begin
      if (h) begin
        act_h_cyc.push_back(cyc);
        act_d.push_back(D);
      end
      if (done) begin
        act_done_cyc.push_back(cyc);
        act_done_val.push_back(sr);
      end
      if (frame_err) act_err_cyc.push_back(cyc);
      if ((done && frame_err) || (h && (done || frame_err))) viol++;
    end
  end

  task automatic clear_events();
    exp_h_cyc.delete();    act_h_cyc.delete();
    exp_d.delete();        act_d.delete();
    exp_done_cyc.delete(); act_done_cyc.delete();
    exp_done_val.delete(); act_done_val.delete();
    exp_err_cyc.delete();  act_err_cyc.delete();
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame from a falling clock edge and predicts its events from the bit timing rules.
  task automatic send_frame(input logic [7:0] data, input bit stop);
    int fall;
    int t0;
    fall = cyc;
    t0   = fall + 3;
    for (int k = 0; k < N; k++) begin
      exp_h_cyc.push_back(t0 + C / 2 + (k + 1) * C);
      exp_d.push_back(data[k]);
    end
    if (stop) begin
      exp_done_cyc.push_back(t0 + C / 2 + (N + 1) * C);
      exp_done_val.push_back(data);
    end else begin
      exp_err_cyc.push_back(t0 + C / 2 + (N + 1) * C);
    end
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      rx = data[k];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
  endtask

  task automatic compare_events(input string tag);
    check_eq($sformatf("%s h_count", tag), act_h_cyc.size(), exp_h_cyc.size());
    for (int i = 0; i < exp_h_cyc.size() && i < act_h_cyc.size(); i++) begin
      check_eq($sformatf("%s h_cyc[%0d]", tag, i), act_h_cyc[i], exp_h_cyc[i]);
      check_eq($sformatf("%s D[%0d]", tag, i), act_d[i], exp_d[i]);
    end
    check_eq($sformatf("%s done_count", tag), act_done_cyc.size(), exp_done_cyc.size());
    for (int i = 0; i < exp_done_cyc.size() && i < act_done_cyc.size(); i++) begin
      check_eq($sformatf("%s done_cyc[%0d]", tag, i), act_done_cyc[i], exp_done_cyc[i]);
      check_eq($sformatf("%s reg_at_done[%0d]", tag, i), act_done_val[i], exp_done_val[i]);
    end
    check_eq($sformatf("%s err_count", tag), act_err_cyc.size(), exp_err_cyc.size());
    for (int i = 0; i < exp_err_cyc.size() && i < act_err_cyc.size(); i++) begin
      check_eq($sformatf("%s err_cyc[%0d]", tag, i), act_err_cyc[i], exp_err_cyc[i]);
    end
    check_eq($sformatf("%s exclusivity_violations", tag), viol, 0);
    clear_events();
  endtask

  initial begin
    int         f;
    int         busy_cnt;
    int         gap;
    int         diff;
    logic [7:0] data;
    bit         stop;

    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst D", D, 0);
    check_eq("rst h", h, 0);
    check_eq("rst done", done, 0);
    check_eq("rst frame_err", frame_err, 0);
    check_eq("rst busy", busy, 0);
    rst = 1'b1;
    idle(4);

    // 0xA5 with a valid stop bit.
    send_frame(8'hA5, 1'b1);
    idle(6);
    compare_events("a5");

    // Two-cycle low glitch: busy only from t0 to the start decision.
    f  = cyc;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("glitch busy@%0d", cyc - f), busy, (cyc >= f + 3 && cyc <= f + 6) ? 1 : 0);
      @(negedge clk);
    end
    idle(4);
    compare_events("glitch");

    // 0x3C with low stop bit, line then held low.
    send_frame(8'h3C, 1'b0);
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      busy_cnt += int'(busy);
    end
    check_eq("held_low busy_cycles", busy_cnt, 0);
    idle(6);
    compare_events("frame_err");
    send_frame(8'h96, 1'b1);
    idle(6);
    compare_events("after_err");

    // Reset in the middle of 0x5A.
    data = 8'h5A;
    rx   = 1'b0;
    repeat (C) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rx = data[k];
      repeat (C) @(negedge clk);
    end
    rx = data[3];
    repeat (2) @(negedge clk);
    check_eq("midframe busy_before_rst", busy, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst D", D, 0);
    check_eq("async_rst h", h, 0);
    check_eq("async_rst done", done, 0);
    check_eq("async_rst frame_err", frame_err, 0);
    check_eq("async_rst busy", busy, 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_events();
    idle(4);
    send_frame(8'h3C, 1'b1);
    idle(6);
    compare_events("post_rst");

    // Back-to-back 0x00 then 0xFF.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(6);
    diff = (act_done_cyc.size() >= 2) ? act_done_cyc[1] - act_done_cyc[0] : -1;
    check_eq("b2b done_spacing", diff, 80);
    compare_events("b2b");

    // Randomized frames, gaps and stop bits.
    for (int n = 0; n < 20; n++) begin
      data = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 6);
      if (rx == 1'b0 && gap == 0) gap = 1;
      idle(gap);
      send_frame(data, stop);
    end
    idle(6);
    compare_events("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
